// File: rtl/vec_ldst_unit.sv
// Vector load/store sequencer: moves one 32x16-bit vector register to/from word memory, one lane per cycle.
// Optional macro VLSU_RANGE_CHECK_EN rejects transfers running past the top of memory; otherwise addresses wrap.
module vec_ldst_unit #(
  parameter int LANES  = 32,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 9,
  parameter int MEM_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [1:0]              reg_sel,
  input  logic [LANES*LANE_W-1:0] store_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [LANES*LANE_W-1:0] load_data,
  output logic [3:0]              reg_wr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [MEM_W-1:0]        mem_wdata,
  input  logic [MEM_W-1:0]        mem_rdata
);
  localparam int LW = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t                        r_state, w_next;
  logic                          r_op;
  logic [ADDR_W-1:0]             r_base;
  logic [1:0]                    r_rsel;
  logic [LW-1:0]                 r_lane;
  logic [LANES-1:0][LANE_W-1:0]  r_sdata;
  logic [LANES-1:0][LANE_W-1:0]  r_cap;
  logic [LANES-1:0][LANE_W-1:0]  r_ldata;
  logic                          w_accept;
  logic                          w_over;
  logic                          w_unused;

  function automatic logic signed [MEM_W-1:0] sext_lane(input logic signed [LANE_W-1:0] v);
    return {{(MEM_W-LANE_W){v[LANE_W-1]}}, v};
  endfunction

`ifdef VLSU_RANGE_CHECK_EN
  logic [ADDR_W:0] w_end;
  logic            r_rej;
  assign w_end  = {1'b0, base_addr} + (ADDR_W+1)'(LANES-1);
  assign w_over = w_end[ADDR_W];
  assign err    = r_rej;
`else
  assign w_over = 1'b0;
  assign err    = 1'b0;
`endif

  // Only the low lane bits of a memory word are kept on loads.
  assign w_unused  = ^mem_rdata[MEM_W-1:LANE_W];
  assign load_data = r_ldata;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    reg_wr    = 4'b0000;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start && !w_over) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy     = 1'b1;
        mem_addr = r_base + ADDR_W'(r_lane);
        mem_re   = !r_op;
        mem_we   = r_op;
        if (r_op) mem_wdata = sext_lane(r_sdata[r_lane]);
        if (r_lane == LW'(LANES-1)) w_next = r_op ? S_FINISH : S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_FINISH;
      end
      S_FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        if (!r_op) reg_wr = 4'b0001 << r_rsel;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
`ifdef VLSU_RANGE_CHECK_EN
    if (r_rej) done = 1'b1;
`endif
  end

  // Control state; load_data is reset too since it is architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_rsel  <= 2'd0;
      r_lane  <= '0;
      r_ldata <= '0;
`ifdef VLSU_RANGE_CHECK_EN
      r_rej   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op;
        r_rsel <= reg_sel;
        r_lane <= '0;
      end else if (r_state == S_ISSUE) begin
        r_lane <= r_lane + 1'b1;
      end
      if (r_state == S_DRAIN) begin
        r_ldata          <= r_cap;
        r_ldata[LANES-1] <= mem_rdata[LANE_W-1:0];
      end
`ifdef VLSU_RANGE_CHECK_EN
      r_rej <= (r_state == S_IDLE) && start && w_over;
`endif
    end
  end

  // Datapath: read data lags the issued lane by one cycle, so capture lane-1.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base  <= base_addr;
      r_sdata <= store_data;
    end
    if (r_state == S_ISSUE && !r_op && r_lane != '0)
      r_cap[r_lane - 1'b1] <= mem_rdata[LANE_W-1:0];
  end

endmodule

// File: tb/tb_vec_ldst_unit.sv
// Self-checking bench for vec_ldst_unit: directed plan cases plus random transfers against a reference model.
module tb_vec_ldst_unit;
  localparam int LANES = 32;
  localparam int VW    = 512;

  logic          clk = 1'b0;
  logic          rst, start, op;
  logic [8:0]    base_addr;
  logic [1:0]    reg_sel;
  logic [VW-1:0] store_data;
  logic          busy, done, err;
  logic [VW-1:0] load_data;
  logic [3:0]    reg_wr;
  logic [8:0]    mem_addr;
  logic          mem_re, mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  vec_ldst_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .base_addr(base_addr),
    .reg_sel(reg_sel), .store_data(store_data), .busy(busy), .done(done),
    .err(err), .load_data(load_data), .reg_wr(reg_wr), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0]   mem     [512];
  logic [31:0]   ref_mem [512];
  logic          mem_init;
  logic [VW-1:0] exp_ldata;
  int            n_chk = 0;
  int            n_err = 0;

  // Synchronous-read memory; returns junk when not reading so late/early capture shows up.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 512; k++) mem[k] <= 32'hABCD0000 | 32'(k);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_re ? mem[mem_addr] : $urandom;
  end

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return 32'(s);
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"},  VW'(busy),      '0);
    check_eq({tag, "_done"},  VW'(done),      '0);
    check_eq({tag, "_err"},   VW'(err),       '0);
    check_eq({tag, "_regwr"}, VW'(reg_wr),    '0);
    check_eq({tag, "_re"},    VW'(mem_re),    '0);
    check_eq({tag, "_we"},    VW'(mem_we),    '0);
    check_eq({tag, "_addr"},  VW'(mem_addr),  '0);
    check_eq({tag, "_wdata"}, VW'(mem_wdata), '0);
    check_eq({tag, "_ldata"}, load_data,      '0);
  endtask

  // Called at the falling edge of an idle cycle (cycle 0); returns at the falling edge
  // of the first idle cycle after the transfer, so transfers run back to back.
  task automatic run_txn(input string name, input bit op_i, input logic [8:0] base_i,
                         input logic [1:0] rsel_i, input logic [VW-1:0] sd_i,
                         input int inj_start, input int rst_at);
    bit            rej;
    bit            aborted;
    int            len;
    logic [VW-1:0] new_ld;
    bit            act;
    rej     = 1'b0;
    aborted = 1'b0;
`ifdef VLSU_RANGE_CHECK_EN
    rej = (int'(base_i) + LANES - 1) > 511;
`endif
    len    = rej ? 1 : (op_i ? LANES + 1 : LANES + 2);
    new_ld = exp_ldata;
    if (!rej && !op_i)
      for (int i = 0; i < LANES; i++) new_ld[16*i +: 16] = ref_mem[(int'(base_i) + i) % 512][15:0];
    start = 1'b1; op = op_i; base_addr = base_i; reg_sel = rsel_i; store_data = sd_i;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start = 1'b0; op = 1'($urandom); base_addr = 9'($urandom);
      reg_sel = 2'($urandom); store_data = rand_vec();
      if (c == inj_start) start = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        check_reset_vals($sformatf("%s_rst", name));
        rst = 1'b0;
        exp_ldata = '0;
        aborted = 1'b1;
        break;
      end
      if (rej) begin
        check_eq($sformatf("%s_c%0d_done", name, c), VW'(done), 1);
        check_eq($sformatf("%s_c%0d_err", name, c),  VW'(err), 1);
        check_eq($sformatf("%s_c%0d_busy", name, c), VW'(busy), 0);
        check_eq($sformatf("%s_c%0d_strb", name, c), VW'({mem_re, mem_we, reg_wr}), 0);
        check_eq($sformatf("%s_c%0d_ldata", name, c), load_data, exp_ldata);
      end else begin
        act = (c <= LANES);
        check_eq($sformatf("%s_c%0d_busy", name, c), VW'(busy), 1);
        check_eq($sformatf("%s_c%0d_done", name, c), VW'(done), VW'(c == len));
        check_eq($sformatf("%s_c%0d_err", name, c),  VW'(err), 0);
        check_eq($sformatf("%s_c%0d_we", name, c),   VW'(mem_we), VW'(op_i && act));
        check_eq($sformatf("%s_c%0d_re", name, c),   VW'(mem_re), VW'(!op_i && act));
        check_eq($sformatf("%s_c%0d_addr", name, c), VW'(mem_addr),
                 act ? VW'((int'(base_i) + c - 1) % 512) : VW'(0));
        check_eq($sformatf("%s_c%0d_wdata", name, c), VW'(mem_wdata),
                 (op_i && act) ? VW'(sx(sd_i[16*(c-1) +: 16])) : VW'(0));
        check_eq($sformatf("%s_c%0d_regwr", name, c), VW'(reg_wr),
                 (!op_i && c == len) ? VW'(4'b0001 << rsel_i) : VW'(0));
        check_eq($sformatf("%s_c%0d_ldata", name, c), load_data,
                 (!op_i && c == len) ? new_ld : exp_ldata);
      end
      if (c == rst_at) rst = 1'b1;
    end
    if (!aborted && !rej) begin
      if (op_i) for (int i = 0; i < LANES; i++) ref_mem[(int'(base_i) + i) % 512] = sx(sd_i[16*i +: 16]);
      else exp_ldata = new_ld;
    end
    @(negedge clk);
    start = 1'b0;
    check_eq($sformatf("%s_idle_busy", name), VW'(busy), 0);
    check_eq($sformatf("%s_idle_done", name), VW'(done), 0);
    check_eq($sformatf("%s_idle_strb", name), VW'({mem_re, mem_we, reg_wr}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] sd;
    rst = 1'b1; start = 1'b0; op = 1'b0; base_addr = '0; reg_sel = '0; store_data = '0;
    mem_init = 1'b1;
    exp_ldata = '0;
    for (int k = 0; k < 512; k++) ref_mem[k] = 32'hABCD0000 | 32'(k);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < LANES; i++) sd[16*i +: 16] = 16'(i - 8);
    run_txn("store16", 1'b1, 9'd16, 2'd0, sd, 0, 0);
    run_txn("load64", 1'b0, 9'd64, 2'd2, rand_vec(), 0, 0);
    run_txn("load16", 1'b0, 9'd16, 2'd1, rand_vec(), 0, 0);
    run_txn("busystart", 1'b0, 9'd100, 2'd3, rand_vec(), 5, 0);
    run_txn("load481", 1'b0, 9'd481, 2'd0, rand_vec(), 0, 0);
    run_txn("store481", 1'b1, 9'd481, 2'd1, rand_vec(), 0, 0);
    run_txn("store490", 1'b1, 9'd490, 2'd2, rand_vec(), 0, 0);
    run_txn("load490", 1'b0, 9'd490, 2'd1, rand_vec(), 0, 0);
    run_txn("load0", 1'b0, 9'd0, 2'd2, rand_vec(), 0, 0);
    run_txn("rstmid", 1'b0, 9'd200, 2'd1, rand_vec(), 0, 12);
    run_txn("afterrst", 1'b0, 9'd16, 2'd3, rand_vec(), 0, 0);
    for (int t = 0; t < 12; t++)
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
              2'($urandom), rand_vec(), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vec_ldst_unit.md
# vec_ldst_unit

Vector load/store sequencer for the 512-bit processor: moves one 512-bit vector register (32 lanes × 16 bits) to or from the 512 × 32-bit data memory. It does this one lane per cycle over a narrow single-word memory port. It is the initiator side of the memory interface: it drives address, read and write strobes, and collects read data. It sits between the decode/control path (start, op, register select) and the word-addressed data memory.

## Interface
- LANES, 32, lanes per vector register
- LANE_W, 16, bits per lane (signed)
- ADDR_W, 9, memory word-address width (512 words)
- MEM_W, 32, memory word width
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse, accepted only in IDLE
- op  input  1  0 = load (memory→register), 1 = store (register→memory)
- base_addr  input  ADDR_W  word address of lane 0
- reg_sel  input  2  destination register for loads (0..3)
- store_data  input  LANES*LANE_W  vector to store, lane i = bits [16i+15:16i]
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse with done when the request is rejected (see Configuration)
- load_data  output  LANES*LANE_W  assembled load vector, held until next load completes
- reg_wr  output  4  one-hot register write strobe, one cycle, coincident with done on a load
- mem_addr  output  ADDR_W  memory word address
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_wdata  output  MEM_W  write data
- mem_rdata  input  MEM_W  read data, valid the cycle after mem_re (synchronous read)

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 latches op, base_addr, reg_sel and store_data. Lane counter is cleared. Next state is ISSUE. start is ignored in every other state.
- ISSUE: drives mem_addr = base_addr + lane and asserts mem_we (store) or mem_re (load), with the lane counter running 0..31.
  - After lane 31, a store goes to FINISH and a load goes to DRAIN.
- Store data: mem_wdata = lane value sign-extended to 32 bits.
- Load capture: lane (counter−1) ← mem_rdata[15:0] on each cycle following a read. Upper 16 bits are discarded.
- DRAIN: captures lane 31, then goes to FINISH.
- FINISH: pulses done for one cycle, then returns to IDLE.
  - On a load, also pulses load_valid semantics via reg_wr[reg_sel]=1, with load_data fully updated in the same cycle.
- load_data lanes are only written from captured data. load_data is unchanged by stores and by rejected requests.
- mem_addr, mem_re, mem_we and mem_wdata are 0 whenever not in ISSUE.

## Timing
- Reset: state=IDLE, busy=0, done=0, err=0, reg_wr=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, load_data=0.
- Cycle numbering: cycle 0 is the cycle with start=1 in IDLE.
- Store:
  - mem_we high cycles 1..32 with addresses base..base+31.
  - done in cycle 33.
  - busy high cycles 1..33.
- Load:
  - mem_re high cycles 1..32.
  - rdata for lane i arrives in cycle i+2.
  - DRAIN in cycle 33; done and reg_wr in cycle 34.
  - busy high cycles 1..34.
- Back-to-back: start may be asserted in the cycle after done, i.e. the first IDLE cycle; there is no dead cycle beyond that.
- rst asserted mid-transfer aborts immediately to reset values. Partially captured lanes are discarded. No done pulse is generated.
- Address arithmetic is ADDR_W bits. Overflow handling is set by the macro below.

## Configuration
- VLSU_RANGE_CHECK_EN defined:
  - In IDLE, start with base_addr + 31 > 511 is rejected.
  - The next cycle pulses done=1 and err=1 together with busy=0.
  - No memory strobes are asserted and no reg_wr pulse occurs.
- VLSU_RANGE_CHECK_EN undefined:
  - err is tied 0.
  - Addresses wrap modulo 512 (e.g. base 500 touches words 500..511, 0..19).

## Test plan
- Store: base=16, lane i = i−8 → cycles 1..32 write addr 16+i with data sign-extended (lane 0 → 0xFFFFFFF8). done in cycle 33; load_data unchanged.
- Load: memory preloaded with word k = 0xABCD0000 | k, base=64, reg_sel=2 → load_data lane i = 64+i, reg_wr=4'b0100 and done in cycle 34.
- Start while busy: second start at cycle 5 of a load → ignored; exactly 32 mem_re cycles and one done.
- Boundary, base=481 (481+31=511): transfer completes, err=0 in both builds. base=490 with VLSU_RANGE_CHECK_EN: done=err=1 in cycle 1, no strobes. Without the macro: addresses 490..511, 0..9.
- Reset mid-load at cycle 12: all outputs at reset values in cycle 13, no done. A fresh load after reset completes normally in 34 cycles.
